gor_accum: RTL

GOR_ACCUM -- requirements
Module: gor_accum

---
 rtl/gor_accum.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/gor_accum.sv
// Purpose : bitwise OR/AND/XOR/NOR unit: single two-operand op, or fold of in_a over a burst.
// Latency : 1 cycle from accepted single beat / accepted in_last beat to out_valid.
// Backpr. : in_ready = !out_valid || out_ready; a held result freezes all outputs and stalls input.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       input beat handshake
//   in_a, in_b, op          operands and operation (00 OR, 01 AND, 10 XOR, 11 NOR)
//   acc_mode, in_last       0: single op; 1: fold in_a over a burst ending at in_last
//   out_valid/out_ready     result handshake
//   out_y, out_any          result and its OR-reduction
//   out_beats, out_ovf      beats folded (saturating at MAX_BEATS), burst overflow flag
module gor_accum #(
    parameter  int WIDTH     = 16,
    parameter  int MAX_BEATS = 255,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       op,
    input  logic             acc_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_any,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_ovf
);

    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [WIDTH-1:0] f_op(input logic [1:0] o,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (o)
            2'b00:   r = x | y;
            2'b01:   r = x & y;
            2'b10:   r = x ^ y;
            default: r = ~(x | y);
        endcase
        return r;
    endfunction

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_op,  w_op_nxt;
    logic             r_ovf, w_ovf_nxt;

    logic             r_out_vld;
    logic [WIDTH-1:0] r_out_y;
    logic             r_out_any;
    logic [CNT_W-1:0] r_out_beats;
    logic             r_out_ovf;

    logic             w_fire;
    logic             w_ld;
    logic [WIDTH-1:0] w_ld_y;
    logic [CNT_W-1:0] w_ld_beats;
    logic             w_ld_ovf;
    logic [WIDTH-1:0] w_fold;

    assign in_ready  = !r_out_vld || out_ready;
    assign w_fire    = in_valid && in_ready;
    assign w_fold    = f_op(r_op, r_acc, in_a);

    assign out_valid = r_out_vld;
    assign out_y     = r_out_y;
    assign out_any   = r_out_any;
    assign out_beats = r_out_beats;
    assign out_ovf   = r_out_ovf;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic: a burst that ends on its first beat never enters ACCUM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_fire && acc_mode && !in_last) w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_fire && in_last)              w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: burst-register updates and result-load strobe
    always_comb begin
        w_acc_nxt  = r_acc;
        w_cnt_nxt  = r_cnt;
        w_op_nxt   = r_op;
        w_ovf_nxt  = r_ovf;
        w_ld       = 1'b0;
        w_ld_y     = w_fold;
        w_ld_beats = CNT_ONE;
        w_ld_ovf   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fire) begin
                    if (!acc_mode) begin
                        w_ld   = 1'b1;
                        w_ld_y = f_op(op, in_a, in_b);
                    end else begin
                        w_acc_nxt = in_a;
                        w_cnt_nxt = CNT_ONE;
                        w_op_nxt  = op;
                        w_ovf_nxt = 1'b0;
                        w_ld      = in_last;
                        w_ld_y    = in_a;
                    end
                end
            end
            S_ACCUM: begin
                if (w_fire) begin
                    w_acc_nxt = w_fold;
                    // Count saturates; the data fold continues regardless
                    if (r_cnt == CNT_MAX) w_ovf_nxt = 1'b1;
                    else                  w_cnt_nxt = r_cnt + CNT_ONE;
                    w_ld       = in_last;
                    w_ld_y     = w_fold;
                    w_ld_beats = w_cnt_nxt;
                    w_ld_ovf   = w_ovf_nxt;
                end
            end
            default: ;
        endcase
    end

    // Burst working registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_op  <= 2'b00;
            r_ovf <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_op  <= w_op_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    // Output register: loads only when in_ready was high, so a held result is never overwritten
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_vld   <= 1'b0;
            r_out_y     <= '0;
            r_out_any   <= 1'b0;
            r_out_beats <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_ld) begin
            r_out_vld   <= 1'b1;
            r_out_y     <= w_ld_y;
            r_out_any   <= |w_ld_y;
            r_out_beats <= w_ld_beats;
            r_out_ovf   <= w_ld_ovf;
        end else if (out_ready) begin
            r_out_vld   <= 1'b0;
        end
    end

endmodule
